// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: the FSM sequences fetch/decode/execute/memory/writeback
// and counts retired instructions.
module multicycle_control #(
  parameter int OPW = 4
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic           Run,
  input  logic [OPW-1:0] Opcode,
  input  logic           Zero,
  input  logic           MemReady,
  output logic           PCWrite,
  output logic           IRWrite,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           RegWrite,
  output logic           Halted,
  output logic [1:0]     PCSrc,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic [2:0]     State,
  output logic [11:0]    InstrCount
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6,
    S_ILLEGAL = 3'd7
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(0);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(4);
  localparam logic [OPW-1:0] OP_JMP   = OPW'(5);
  localparam logic [OPW-1:0] OP_HALT  = OPW'(15);

  state_t         state_reg, state_next;
  logic [11:0]    count_reg, count_next;
  logic [OPW-1:0] opcode_reg, opcode_next;
  logic [4:0]     is_op;
  logic           is_rtype, is_addi, is_lw, is_sw, is_beq;
  logic           retire;

  // One-hot class flags from the opcode captured in DECODE.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_dec
      assign is_op[gi] = (opcode_reg == OPW'(gi));
    end
  endgenerate

  assign is_rtype = is_op[0];
  assign is_addi  = is_op[1];
  assign is_lw    = is_op[2];
  assign is_sw    = is_op[3];
  assign is_beq   = is_op[4];

  assign opcode_next = (state_reg == S_DECODE) ? Opcode : opcode_reg;

  // Entering FETCH from IDLE starts the machine and is not a retirement.
  assign retire = (state_next == S_FETCH) &&
                  ((state_reg == S_DECODE) || (state_reg == S_EXEC) ||
                   (state_reg == S_MEM)    || (state_reg == S_WB));
  assign count_next = count_reg + {11'd0, retire};

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg  <= S_IDLE;
      count_reg  <= '0;
      opcode_reg <= '0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      opcode_reg <= opcode_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (Run) state_next = S_FETCH;
      S_FETCH:  if (MemReady) state_next = S_DECODE;
      S_DECODE: begin
        if (Opcode <= OP_BEQ)       state_next = S_EXEC;
        else if (Opcode == OP_HALT) state_next = S_HALT;
        else                        state_next = S_FETCH;
      end
      S_EXEC: begin
        if (is_rtype || is_addi)  state_next = S_WB;
        else if (is_lw || is_sw)  state_next = S_MEM;
        else                      state_next = S_FETCH;
      end
      S_MEM: begin
        if (!(is_lw || is_sw))    state_next = S_FETCH;
        else if (MemReady)        state_next = is_lw ? S_WB : S_FETCH;
      end
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_HALT;
    endcase
  end

  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    Halted   = 1'b0;
    PCSrc    = 2'b00;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    case (state_reg)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        if (Opcode == OP_JMP) begin
          PCWrite = 1'b1;
          PCSrc   = 2'b10;
        end
      end
      S_EXEC: begin
        if (is_rtype) begin
          ALUOp = 2'b10;
        end else if (is_addi || is_lw || is_sw) begin
          ALUSrcB = 2'b10;
        end else if (is_beq) begin
          ALUOp   = 2'b01;
          PCWrite = Zero;
          PCSrc   = 2'b01;
        end
      end
      S_MEM: begin
        MemRead  = is_lw;
        MemWrite = is_sw;
      end
      S_WB:    RegWrite = 1'b1;
      S_HALT:  Halted = 1'b1;
      default: ;
    endcase
  end

  assign State      = state_reg;
  assign InstrCount = count_reg;

  // Keeps the R-type opcode constant referenced for readers; decode uses is_op[0].
  logic unused_ok;
  assign unused_ok = &{1'b0, OP_RTYPE};

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is expanded into its
// expected per-cycle phase sequence and compared against the DUT cycle by cycle.
module tb_multicycle_control;

  logic        CLK = 1'b0;
  logic        Reset, Run, Zero, MemReady;
  logic [3:0]  Opcode;
  logic        PCWrite, IRWrite, MemRead, MemWrite, RegWrite, Halted;
  logic [1:0]  PCSrc, ALUSrcB, ALUOp;
  logic [2:0]  State;
  logic [11:0] InstrCount;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [11:0] exp_count = '0;

  // Control word layout: {PCWrite,IRWrite,MemRead,MemWrite,RegWrite,Halted,PCSrc,ALUSrcB,ALUOp}
  localparam logic [11:0] C_NONE  = 12'b000000_00_00_00;
  localparam logic [11:0] C_FWAIT = 12'b001000_00_01_00;
  localparam logic [11:0] C_FDONE = 12'b111000_00_01_00;
  localparam logic [11:0] C_DEC   = 12'b000000_00_11_00;
  localparam logic [11:0] C_DJMP  = 12'b100000_10_11_00;
  localparam logic [11:0] C_EXR   = 12'b000000_00_00_10;
  localparam logic [11:0] C_EXI   = 12'b000000_00_10_00;
  localparam logic [11:0] C_MRD   = 12'b001000_00_00_00;
  localparam logic [11:0] C_MWR   = 12'b000100_00_00_00;
  localparam logic [11:0] C_WB    = 12'b000010_00_00_00;
  localparam logic [11:0] C_HALT  = 12'b000001_00_00_00;
  localparam logic [11:0] C_BEQ0  = 12'b000000_01_00_01;
  localparam logic [11:0] C_BEQ1  = 12'b100000_01_00_01;

  multicycle_control #(.OPW(4)) dut (
    .CLK(CLK), .Reset(Reset), .Run(Run), .Opcode(Opcode), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .Halted(Halted), .PCSrc(PCSrc),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .State(State), .InstrCount(InstrCount)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] ro();
    return 4'($urandom_range(0, 15));
  endfunction

  // One clock cycle: drive inputs, compare at the falling edge, advance past the rising edge.
  task automatic step(input logic [2:0] st, input logic [11:0] c, input logic rst,
                      input logic run, input logic mr, input logic [3:0] op, input logic z);
    Reset = rst; Run = run; MemReady = mr; Opcode = op; Zero = z;
    @(negedge CLK);
    check("state", 32'(State), 32'(st));
    check("ctrl", 32'({PCWrite, IRWrite, MemRead, MemWrite, RegWrite, Halted, PCSrc, ALUSrcB, ALUOp}),
          32'(c));
    check("count", 32'(InstrCount), 32'(exp_count));
    @(posedge CLK);
    #1;
  endtask

  task automatic start_run();
    step(3'd0, C_NONE, 1'b0, 1'b1, rb(), ro(), rb());
  endtask

  task automatic run_instr(input logic [3:0] op, input int fw, input int mw, input logic z,
                           input bit rst_mem, input bit verbose, output bit idle);
    logic [11:0] mctl;
    idle = 1'b0;
    for (int i = 0; i < fw; i++) step(3'd1, C_FWAIT, 1'b0, rb(), 1'b0, ro(), rb());
    step(3'd1, C_FDONE, 1'b0, rb(), 1'b1, ro(), rb());
    step(3'd2, (op == 4'd5) ? C_DJMP : C_DEC, 1'b0, rb(), rb(), op, rb());
    case (op)
      4'd0, 4'd1: begin
        step(3'd3, (op == 4'd0) ? C_EXR : C_EXI, 1'b0, rb(), rb(), ro(), rb());
        step(3'd5, C_WB, 1'b0, rb(), rb(), ro(), rb());
      end
      4'd2, 4'd3: begin
        step(3'd3, C_EXI, 1'b0, rb(), rb(), ro(), rb());
        mctl = (op == 4'd2) ? C_MRD : C_MWR;
        for (int i = 0; i < mw; i++) step(3'd4, mctl, 1'b0, rb(), 1'b0, ro(), rb());
        if (rst_mem) begin
          step(3'd4, mctl, 1'b1, rb(), rb(), ro(), rb());
          exp_count = '0;
          idle = 1'b1;
        end else begin
          step(3'd4, mctl, 1'b0, rb(), 1'b1, ro(), rb());
          if (op == 4'd2) step(3'd5, C_WB, 1'b0, rb(), rb(), ro(), rb());
        end
      end
      4'd4: step(3'd3, z ? C_BEQ1 : C_BEQ0, 1'b0, rb(), rb(), ro(), z);
      4'd15: begin
        for (int i = 0; i < 4; i++) step(3'd6, C_HALT, 1'b0, 1'b1, rb(), ro(), rb());
        step(3'd6, C_HALT, 1'b1, rb(), rb(), ro(), rb());
        exp_count = '0;
        idle = 1'b1;
      end
      default: ;
    endcase
    if (!idle) exp_count = exp_count + 12'd1;
    if (verbose)
      $display("instr op=%0d fetch_wait=%0d mem_wait=%0d zero=%0d reset_in_mem=%0d count=%0d",
               op, fw, mw, z, rst_mem, exp_count);
  endtask

  initial begin
    bit          idle;
    logic [3:0]  op;
    int          r;

    // Reset held two cycles, then five idle cycles with Run low.
    Reset = 1'b1; Run = 1'b0; MemReady = 1'b0; Opcode = '0; Zero = 1'b0;
    @(posedge CLK);
    #1;
    step(3'd0, C_NONE, 1'b1, 1'b0, rb(), ro(), rb());
    for (int i = 0; i < 5; i++) step(3'd0, C_NONE, 1'b0, 1'b0, rb(), ro(), rb());
    $display("reset check done count=%0d", exp_count);

    // Directed: R-type, LW with memory wait, BEQ taken and not taken.
    start_run();
    run_instr(4'd0, 0, 0, 1'b0, 1'b0, 1'b1, idle);
    run_instr(4'd2, 1, 3, 1'b0, 1'b0, 1'b1, idle);
    run_instr(4'd4, 0, 0, 1'b1, 1'b0, 1'b1, idle);
    run_instr(4'd4, 2, 0, 1'b0, 1'b0, 1'b1, idle);

    // Randomized instruction stream.
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 19);
      if (r < 12)      op = 4'(r % 5);
      else if (r < 14) op = 4'd5;
      else if (r < 19) op = 4'($urandom_range(6, 14));
      else             op = 4'd15;
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), rb(),
                ((op == 4'd2) || (op == 4'd3)) && ($urandom_range(0, 9) == 0), 1'b1, idle);
      if (idle) begin
        step(3'd0, C_NONE, 1'b0, 1'b0, rb(), ro(), rb());
        start_run();
      end
    end

    // Directed HALT: Run ignored until reset.
    run_instr(4'd15, 0, 0, 1'b0, 1'b0, 1'b1, idle);
    step(3'd0, C_NONE, 1'b0, 1'b0, rb(), ro(), rb());

    // Counter wrap: 4096 retirements from zero bring InstrCount back to 0.
    start_run();
    for (int n = 0; n < 4096; n++) run_instr(4'($urandom_range(6, 14)), 0, 0, 1'b0, 1'b0, 1'b0, idle);
    step(3'd1, C_FWAIT, 1'b0, rb(), 1'b0, ro(), rb());
    $display("wrap check after 4096 retirements count=%0d", exp_count);

    // Reset while waiting in MEM.
    run_instr(4'd1, 1, 0, 1'b0, 1'b0, 1'b1, idle);
    run_instr(4'd2, 0, 2, 1'b0, 1'b1, 1'b1, idle);
    step(3'd0, C_NONE, 1'b0, 1'b0, rb(), ro(), rb());
    start_run();
    run_instr(4'd3, 0, 2, 1'b0, 1'b1, 1'b1, idle);
    step(3'd0, C_NONE, 1'b0, 1'b0, rb(), ro(), rb());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
